// File: rtl/request_queue_if.sv
// rtl/request_queue_if.sv - shared request types and parser/scheduler-facing interface of request_queue

package request_queue_pkg;

  localparam int QUEUE_SIZE           = 16;
  localparam int PARSER_ADDRESS_WIDTH = 33;

  typedef logic [31:0] int_t;
  typedef logic [19:0] age_counter_t;

  // Ages stop here so the scheduler never sees a young-looking wrapped entry
  localparam age_counter_t AGE_MAX = 20'd999999;

  typedef enum logic [2:0] {
    NOP        = 3'd0,
    DATA_READ  = 3'd1,
    DATA_WRITE = 3'd2,
    INSTR_READ = 3'd3
  } parsed_op_t;

  typedef struct packed {
    logic                              op_ready_s;
    parsed_op_t                        opcode;
    logic [PARSER_ADDRESS_WIDTH-1:0]   address;
    int_t                              time_cpu;
  } parser_out_struct_t;

endpackage

interface request_queue_if
  import request_queue_pkg::*;
#(
  parameter int DEPTH         = QUEUE_SIZE,
  parameter int ADDRESS_WIDTH = 33
);

  parser_out_struct_t               in_req;
  logic                             pop_s;
  logic                             full;
  logic                             empty;
  logic [$clog2(DEPTH+1)-1:0]       count;
  parsed_op_t                       head_opcode;
  logic [ADDRESS_WIDTH-1:0]         head_address;
  int_t                             head_time_cpu;
  age_counter_t                     head_age;
  logic                             overflow_err;

  // Producer/consumer side: parser pushes, scheduler pops and watches the head
  modport master (
    output in_req,
    output pop_s,
    input  full,
    input  empty,
    input  count,
    input  head_opcode,
    input  head_address,
    input  head_time_cpu,
    input  head_age,
    input  overflow_err
  );

  // Queue side
  modport slave (
    input  in_req,
    input  pop_s,
    output full,
    output empty,
    output count,
    output head_opcode,
    output head_address,
    output head_time_cpu,
    output head_age,
    output overflow_err
  );

endinterface

// File: rtl/request_queue.sv
// rtl/request_queue.sv - in-order show-ahead request buffer with per-entry aging

module request_queue
  import request_queue_pkg::*;
#(
  parameter int DEPTH         = QUEUE_SIZE,
  parameter int ADDRESS_WIDTH = 33
) (
  input logic            clock,
  input logic            reset_n,
  request_queue_if.slave rq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  parsed_op_t               mem_opcode   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_address  [DEPTH];
  int_t                     mem_time_cpu [DEPTH];
  age_counter_t             mem_age      [DEPTH];

  logic             full_w;
  logic             empty_w;
  logic             push_acc;
  logic             pop_acc;
  logic [DEPTH-1:0] entry_valid;

  assign full_w   = (count_q == CNT_W'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign push_acc = rq.in_req.op_ready_s && !full_w;
  assign pop_acc  = rq.pop_s && !empty_w;

  // An entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = (CNT_W'(offset) < count_q);
    end
  end

  // Pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A push that meets a same-cycle pop at full is refused but not an overrun:
      // the parser is simply one cycle early for the slot being freed
      if (rq.in_req.op_ready_s && full_w && !pop_acc) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Payload storage; contents are only meaningful where entry_valid is set
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem_opcode[wr_ptr]   <= rq.in_req.opcode;
      mem_address[wr_ptr]  <= ADDRESS_WIDTH'(rq.in_req.address);
      mem_time_cpu[wr_ptr] <= rq.in_req.time_cpu;
    end
  end

  // Ages: cleared on write, otherwise count up on live entries until saturation
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_acc && (wr_ptr == PTR_W'(i))) begin
          mem_age[i] <= '0;
        end else if (entry_valid[i] && (mem_age[i] < AGE_MAX)) begin
          mem_age[i] <= mem_age[i] + age_counter_t'(1);
        end
      end
    end
  end

  // Show-ahead head view, blanked while the queue is empty
  always_comb begin
    rq.head_opcode   = NOP;
    rq.head_address  = '0;
    rq.head_time_cpu = '0;
    rq.head_age      = '0;
    if (!empty_w) begin
      rq.head_opcode   = mem_opcode[rd_ptr];
      rq.head_address  = mem_address[rd_ptr];
      rq.head_time_cpu = mem_time_cpu[rd_ptr];
      rq.head_age      = mem_age[rd_ptr];
    end
  end

  assign rq.full         = full_w;
  assign rq.empty        = empty_w;
  assign rq.count        = count_q;
  assign rq.overflow_err = overflow_q;

endmodule

// File: tb/tb_request_queue.sv
// tb/tb_request_queue.sv - directed self-checking bench for request_queue

module tb_request_queue;
  import request_queue_pkg::*;

  logic clock;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  request_queue_if #(.DEPTH(16), .ADDRESS_WIDTH(33)) rq ();

  request_queue #(.DEPTH(16), .ADDRESS_WIDTH(33)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rq      (rq.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic rdy, input parsed_op_t op, input logic [32:0] a, input int_t t);
    rq.in_req = '{op_ready_s: rdy, opcode: op, address: a, time_cpu: t};
  endtask

  task automatic idle_in();
    set_in(1'b0, NOP, 33'h0, 32'h0);
    rq.pop_s = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle_in();
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic push_one(input parsed_op_t op, input logic [32:0] a, input int_t t);
    set_in(1'b1, op, a, t);
    cycle();
    idle_in();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(1'b1, DATA_READ, 33'h0_0000_0040, 32'd55);
    rq.pop_s = 1'b1;
    cycle();
    cycle();
    cycle();
    tests_run++;
    if (rq.empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_empty: got %b expected 1", rq.empty);
    end
    tests_run++;
    if (rq.full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_full: got %b expected 0", rq.full);
    end
    tests_run++;
    if (rq.count !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d expected 0", rq.count);
    end
    tests_run++;
    if (rq.head_opcode !== NOP || rq.head_address !== 33'h0 || rq.head_time_cpu !== 32'h0 || rq.head_age !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_head: got op=%0d addr=%0h t=%0d age=%0d expected NOP/0/0/0",
               rq.head_opcode, rq.head_address, rq.head_time_cpu, rq.head_age);
    end
    tests_run++;
    if (rq.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_overflow: got %b expected 0", rq.overflow_err);
    end
    idle_in();
    reset_n = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if (rq.count !== 5'd0 || rq.empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: got count=%0d empty=%b expected 0/1", rq.count, rq.empty);
    end
  endtask

  task automatic test_single_transfer();
    apply_reset();
    push_one(DATA_WRITE, 33'h1_2345_6780, 32'd7);
    tests_run++;
    if (rq.empty !== 1'b0 || rq.head_age !== 20'd0) begin
      tests_failed++;
      $display("FAIL single_latency: got empty=%b age=%0d expected 0/0", rq.empty, rq.head_age);
    end
    for (int i = 0; i < 10; i++) cycle();
    tests_run++;
    if (rq.head_opcode !== DATA_WRITE || rq.head_address !== 33'h1_2345_6780 || rq.head_time_cpu !== 32'd7) begin
      tests_failed++;
      $display("FAIL single_fields: got op=%0d addr=%0h t=%0d expected 2/123456780/7",
               rq.head_opcode, rq.head_address, rq.head_time_cpu);
    end
    tests_run++;
    if (rq.head_age !== 20'd10) begin
      tests_failed++;
      $display("FAIL single_age: got %0d expected 10", rq.head_age);
    end
    rq.pop_s = 1'b1;
    cycle();
    rq.pop_s = 1'b0;
    tests_run++;
    if (rq.empty !== 1'b1 || rq.head_opcode !== NOP || rq.head_age !== 20'd0) begin
      tests_failed++;
      $display("FAIL single_pop: got empty=%b op=%0d age=%0d expected 1/NOP/0", rq.empty, rq.head_opcode, rq.head_age);
    end
    rq.pop_s = 1'b1;
    cycle();
    rq.pop_s = 1'b0;
    tests_run++;
    if (rq.count !== 5'd0 || rq.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL pop_when_empty: got count=%0d ovf=%b expected 0/0", rq.count, rq.overflow_err);
    end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      push_one((i % 2 == 0) ? DATA_READ : DATA_WRITE, 33'(i * 16 + 33'h1_0000_0000), int_t'(100 + i));
    end
    tests_run++;
    if (rq.full !== 1'b1 || rq.count !== 5'd16 || rq.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full: got full=%b count=%0d ovf=%b expected 1/16/0", rq.full, rq.count, rq.overflow_err);
    end
    push_one(INSTR_READ, 33'h0_0BAD_0000, 32'd999);
    tests_run++;
    if (rq.overflow_err !== 1'b1 || rq.count !== 5'd16) begin
      tests_failed++;
      $display("FAIL overflow_set: got ovf=%b count=%0d expected 1/16", rq.overflow_err, rq.count);
    end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rq.head_time_cpu !== int_t'(100 + i) || rq.head_address !== 33'(i * 16 + 33'h1_0000_0000)) begin
        tests_failed++;
        $display("FAIL fill_order[%0d]: got t=%0d addr=%0h expected t=%0d", i, rq.head_time_cpu, rq.head_address, 100 + i);
      end
      rq.pop_s = 1'b1;
      cycle();
      rq.pop_s = 1'b0;
    end
    tests_run++;
    if (rq.empty !== 1'b1 || rq.overflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_end: got empty=%b ovf=%b expected 1/1", rq.empty, rq.overflow_err);
    end
    apply_reset();
    tests_run++;
    if (rq.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: got %b expected 0", rq.overflow_err);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 5; i++) push_one(DATA_READ, 33'(i), int_t'(200 + i));
    set_in(1'b1, DATA_WRITE, 33'h5, 32'd205);
    rq.pop_s = 1'b1;
    cycle();
    idle_in();
    tests_run++;
    if (rq.count !== 5'd5 || rq.head_time_cpu !== 32'd201) begin
      tests_failed++;
      $display("FAIL simul_partial: got count=%0d t=%0d expected 5/201", rq.count, rq.head_time_cpu);
    end
    for (int i = 0; i < 11; i++) push_one(DATA_READ, 33'(6 + i), int_t'(206 + i));
    tests_run++;
    if (rq.full !== 1'b1 || rq.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_prefull: got full=%b ovf=%b expected 1/0", rq.full, rq.overflow_err);
    end
    set_in(1'b1, DATA_WRITE, 33'h11, 32'd217);
    rq.pop_s = 1'b1;
    cycle();
    idle_in();
    tests_run++;
    if (rq.count !== 5'd15 || rq.full !== 1'b0 || rq.overflow_err !== 1'b0 || rq.head_time_cpu !== 32'd202) begin
      tests_failed++;
      $display("FAIL simul_full: got count=%0d full=%b ovf=%b t=%0d expected 15/0/0/202",
               rq.count, rq.full, rq.overflow_err, rq.head_time_cpu);
    end
    push_one(DATA_READ, 33'h12, 32'd218);
    tests_run++;
    if (rq.count !== 5'd16 || rq.full !== 1'b1) begin
      tests_failed++;
      $display("FAIL refill_after_pop: got count=%0d full=%b expected 16/1", rq.count, rq.full);
    end
    for (int i = 0; i < 14; i++) begin
      rq.pop_s = 1'b1;
      cycle();
    end
    rq.pop_s = 1'b0;
    tests_run++;
    if (rq.head_time_cpu !== 32'd216) begin
      tests_failed++;
      $display("FAIL simul_order: got t=%0d expected 216", rq.head_time_cpu);
    end
    rq.pop_s = 1'b1;
    cycle();
    rq.pop_s = 1'b0;
    tests_run++;
    if (rq.head_time_cpu !== 32'd218) begin
      tests_failed++;
      $display("FAIL simul_dropped: got t=%0d expected 218", rq.head_time_cpu);
    end
  endtask

  task automatic test_wrap_around();
    int   ph_push [5] = '{1, 1, 0, 1, 0};
    int   ph_pop  [5] = '{0, 1, 1, 1, 1};
    int   ph_len  [5] = '{12, 20, 9, 8, 3};
    int_t sb [$];
    int   pushes;
    pushes = 0;
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < ph_len[p]; c++) begin
        if (ph_pop[p] != 0) begin
          tests_run++;
          if (rq.head_time_cpu !== sb[0]) begin
            tests_failed++;
            $display("FAIL wrap_order: got t=%0d expected %0d", rq.head_time_cpu, sb[0]);
          end
        end
        rq.pop_s = (ph_pop[p] != 0);
        if (ph_push[p] != 0) set_in(1'b1, DATA_READ, 33'(pushes), int_t'(1000 + pushes));
        else                 set_in(1'b0, NOP, 33'h0, 32'h0);
        cycle();
        if (ph_pop[p] != 0) void'(sb.pop_front());
        if (ph_push[p] != 0) begin
          sb.push_back(int_t'(1000 + pushes));
          pushes++;
        end
      end
      idle_in();
      tests_run++;
      if (rq.count !== 5'(sb.size())) begin
        tests_failed++;
        $display("FAIL wrap_count[%0d]: got %0d expected %0d", p, rq.count, sb.size());
      end
    end
    tests_run++;
    if (rq.empty !== 1'b1 || rq.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_end: got empty=%b ovf=%b expected 1/0", rq.empty, rq.overflow_err);
    end
  endtask

  task automatic test_age_saturation();
    apply_reset();
    push_one(INSTR_READ, 33'h0_0000_0100, 32'd42);
    dut.mem_age[0] = 20'd999998;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (rq.head_age !== 20'd999999) begin
        tests_failed++;
        $display("FAIL age_saturate[%0d]: got %0d expected 999999", i, rq.head_age);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    idle_in();
    test_reset();
    test_single_transfer();
    test_fill_overflow();
    test_simultaneous();
    test_wrap_around();
    test_age_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
